// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between instruction
// fetch (read-only) and load/store, with a fixed multi-cycle access latency.
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              In_IFReq,
    input  logic [ADDR_W-1:0] In_IFAddress,
    output logic [DATA_W-1:0] Out_IFData,
    output logic              Out_IFAck,
    input  logic [1:0]        In_MEMControl,
    input  logic [ADDR_W-1:0] In_MEMAddress,
    input  logic [DATA_W-1:0] In_MEMData,
    output logic [DATA_W-1:0] Out_MEMData,
    output logic              Out_MEMAck,
    output logic              Out_Stall,
    output logic [ADDR_W-1:0] Out_MemAddr,
    output logic [DATA_W-1:0] Out_MemWData,
    output logic              Out_MemRead,
    output logic              Out_MemWrite,
    input  logic [DATA_W-1:0] In_MemRData,
    output logic [1:0]        Out_DbgState
);

    // Debug encoding: 0 = IDLE, 1 = ACCESS, 2 = RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_count;
    logic              r_last_mem;
    logic              r_grant_mem;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_data;

    logic w_if_req;
    logic w_mem_req;
    logic w_grant_mem;
    logic w_start;
    logic w_done;

    assign w_if_req  = In_IFReq;
    assign w_mem_req = |In_MEMControl;
    // On a tie the requester that did not win last time goes first.
    assign w_grant_mem = w_mem_req & (~w_if_req | ~r_last_mem);
    assign w_start     = (r_state == IDLE) & (w_if_req | w_mem_req);
    assign w_done      = (r_state == ACCESS) & (r_count == 4'd0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Out_MemRead  = 1'b0;
        Out_MemWrite = 1'b0;
        Out_MemAddr  = '0;
        Out_MemWData = '0;
        Out_IFAck    = 1'b0;
        Out_MEMAck   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_next_state = ACCESS;
            end
            ACCESS: begin
                Out_MemAddr  = r_addr;
                Out_MemRead  = ~r_write;
                Out_MemWrite = r_write;
                if (r_write) Out_MemWData = r_wdata;
                if (w_done) w_next_state = RESP;
            end
            RESP: begin
                Out_IFAck    = ~r_grant_mem;
                Out_MEMAck   = r_grant_mem;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count     <= '0;
            r_last_mem  <= 1'b0;
            r_grant_mem <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_data   <= '0;
            r_mem_data  <= '0;
        end else begin
            if (w_start) begin
                r_grant_mem <= w_grant_mem;
                r_last_mem  <= w_grant_mem;
                r_addr      <= w_grant_mem ? In_MEMAddress : In_IFAddress;
                r_wdata     <= In_MEMData;
                // Op 2'b11 carries the write bit, so it is handled as a store.
                r_write     <= w_grant_mem & In_MEMControl[0];
                r_count     <= LAT_M1;
            end else if ((r_state == ACCESS) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_done && !r_write) begin
                if (r_grant_mem) r_mem_data <= In_MemRData;
                else             r_if_data  <= In_MemRData;
            end
        end
    end

    assign Out_IFData   = r_if_data;
    assign Out_MEMData  = r_mem_data;
    assign Out_Stall    = (w_if_req | w_mem_req) & ~(Out_IFAck | Out_MEMAck);
    assign Out_DbgState = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int LATENCY = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              In_IFReq = 1'b0;
    logic [ADDR_W-1:0] In_IFAddress = '0;
    logic [DATA_W-1:0] Out_IFData;
    logic              Out_IFAck;
    logic [1:0]        In_MEMControl = 2'b00;
    logic [ADDR_W-1:0] In_MEMAddress = '0;
    logic [DATA_W-1:0] In_MEMData = '0;
    logic [DATA_W-1:0] Out_MEMData;
    logic              Out_MEMAck;
    logic              Out_Stall;
    logic [ADDR_W-1:0] Out_MemAddr;
    logic [DATA_W-1:0] Out_MemWData;
    logic              Out_MemRead;
    logic              Out_MemWrite;
    logic [DATA_W-1:0] In_MemRData;
    logic [1:0]        Out_DbgState;

    mem_port_arbiter #(.LATENCY(LATENCY), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_IFReq(In_IFReq), .In_IFAddress(In_IFAddress),
        .Out_IFData(Out_IFData), .Out_IFAck(Out_IFAck),
        .In_MEMControl(In_MEMControl), .In_MEMAddress(In_MEMAddress),
        .In_MEMData(In_MEMData), .Out_MEMData(Out_MEMData), .Out_MEMAck(Out_MEMAck),
        .Out_Stall(Out_Stall), .Out_MemAddr(Out_MemAddr), .Out_MemWData(Out_MemWData),
        .Out_MemRead(Out_MemRead), .Out_MemWrite(Out_MemWrite),
        .In_MemRData(In_MemRData), .Out_DbgState(Out_DbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a << 2;
    endfunction

    // Read data is only valid in the final strobe cycle; other cycles carry junk.
    int strobe_run;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                         strobe_run <= 0;
        else if (Out_MemRead | Out_MemWrite) strobe_run <= strobe_run + 1;
        else                                strobe_run <= 0;
    end
    assign In_MemRData = (Out_MemRead && strobe_run == LATENCY - 1) ?
                         mem_word(Out_MemAddr) : (32'hBAD0_0000 ^ 32'(strobe_run));

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A granted transaction lives LATENCY+1 cycles: LATENCY strobe cycles then
    // one ack cycle; arbitration resumes one edge after the ack cycle ends.
    logic        m_active, m_who_mem, m_write, m_last_mem;
    int          m_age;
    logic [31:0] m_addr, m_wdata, m_ifdata, m_memdata;
    logic        m_pick_mem;

    assign m_pick_mem = (In_MEMControl != 2'b00) && (!In_IFReq || !m_last_mem);

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_active <= 1'b0; m_age <= 0; m_who_mem <= 1'b0; m_write <= 1'b0;
            m_last_mem <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_ifdata <= '0; m_memdata <= '0;
        end else if (m_active) begin
            if (m_age == LATENCY) begin
                m_active <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 == LATENCY && !m_write) begin
                    if (m_who_mem) m_memdata <= mem_word(m_addr);
                    else           m_ifdata  <= mem_word(m_addr);
                end
            end
        end else if (In_IFReq || In_MEMControl != 2'b00) begin
            m_active   <= 1'b1;
            m_age      <= 0;
            m_who_mem  <= m_pick_mem;
            m_last_mem <= m_pick_mem;
            m_addr     <= m_pick_mem ? In_MEMAddress : In_IFAddress;
            m_wdata    <= In_MEMData;
            m_write    <= m_pick_mem && In_MEMControl[0];
        end
    end

    logic e_access, e_ack, e_ifack, e_memack, e_read, e_writ, e_stall;
    assign e_access = m_active && (m_age < LATENCY);
    assign e_ack    = m_active && (m_age == LATENCY);
    assign e_ifack  = e_ack && !m_who_mem;
    assign e_memack = e_ack && m_who_mem;
    assign e_read   = e_access && !m_write;
    assign e_writ   = e_access && m_write;
    assign e_stall  = (In_IFReq || In_MEMControl != 2'b00) && !(e_ifack || e_memack);

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    always @(negedge Clk) begin
        if (chk_en) begin
            check("state",  32'(Out_DbgState), e_access ? 32'd1 : (e_ack ? 32'd2 : 32'd0));
            check("maddr",  Out_MemAddr,  e_access ? m_addr : 32'd0);
            check("mwdata", Out_MemWData, e_writ ? m_wdata : 32'd0);
            check("mread",  32'(Out_MemRead),  32'(e_read));
            check("mwrite", 32'(Out_MemWrite), 32'(e_writ));
            check("ifack",  32'(Out_IFAck),    32'(e_ifack));
            check("memack", 32'(Out_MEMAck),   32'(e_memack));
            check("ifdata", Out_IFData,  m_ifdata);
            check("memdata", Out_MEMData, m_memdata);
            check("stall",  32'(Out_Stall), 32'(e_stall));
        end
    end

    // ---------------- random requester agents ----------------
    logic rand_en = 1'b0;
    always @(posedge Clk) begin
        #1;
        if (rand_en) begin
            if (In_IFReq && Out_IFAck)                     In_IFReq = 1'b0;
            else if (In_IFReq && $urandom_range(0, 15) == 0) In_IFReq = 1'b0;
            else if (!In_IFReq && $urandom_range(0, 2) == 0) begin
                In_IFReq     = 1'b1;
                In_IFAddress = $urandom_range(0, 1023);
            end
            if (In_IFReq && $urandom_range(0, 7) == 0) In_IFAddress = $urandom_range(0, 1023);

            if (In_MEMControl != 2'b00 && Out_MEMAck)                     In_MEMControl = 2'b00;
            else if (In_MEMControl != 2'b00 && $urandom_range(0, 15) == 0) In_MEMControl = 2'b00;
            else if (In_MEMControl == 2'b00 && $urandom_range(0, 2) == 0) begin
                In_MEMControl = 2'($urandom_range(1, 3));
                In_MEMAddress = $urandom_range(0, 1023);
                In_MEMData    = $urandom;
            end
            if (In_MEMControl != 2'b00 && $urandom_range(0, 7) == 0) begin
                In_MEMAddress = $urandom_range(0, 1023);
                In_MEMData    = $urandom;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic mem_access(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] data, output int ack_cyc, output int strobes);
        @(posedge Clk); #1;
        In_MEMControl = op; In_MEMAddress = addr; In_MEMData = data;
        ack_cyc = 0; strobes = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk); #1;
            if (Out_MemRead || Out_MemWrite) strobes++;
            if (Out_MEMAck) begin ack_cyc = n; break; end
        end
        In_MEMControl = 2'b00;
        if (ack_cyc == 0) check("mem_ack_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ack_cyc, strobes, if_cyc, mem_cyc, acks;
        repeat (3) @(posedge Clk);
        chk_en = 1'b1;
        @(negedge Clk);
        Rst_n = 1'b1;

        // Idle after reset
        repeat (10) @(posedge Clk);
        #1;
        check("idle_state", 32'(Out_DbgState), 32'd0);
        check("idle_stall", 32'(Out_Stall), 32'd0);

        // MEM load from address 2
        mem_access(2'b10, 32'd2, 32'd0, ack_cyc, strobes);
        check("load_ack_cycle", 32'(ack_cyc), 32'd3);
        check("load_strobes", 32'(strobes), 32'd2);
        check("load_data", Out_MEMData, 32'd8);

        // MEM store of 8 to address 8
        mem_access(2'b01, 32'd8, 32'd8, ack_cyc, strobes);
        check("store_ack_cycle", 32'(ack_cyc), 32'd3);
        check("store_strobes", 32'(strobes), 32'd2);
        check("store_keeps_data", Out_MEMData, 32'd8);

        // Simultaneous IF and MEM from reset: MEM wins first
        do_reset();
        @(posedge Clk); #1;
        In_IFReq = 1'b1; In_IFAddress = 32'h40;
        In_MEMControl = 2'b10; In_MEMAddress = 32'h10;
        if_cyc = 0; mem_cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk); #1;
            if (Out_MEMAck) begin mem_cyc = n; In_MEMControl = 2'b00; end
            if (Out_IFAck)  begin if_cyc = n;  In_IFReq = 1'b0; end
            if (if_cyc != 0 && mem_cyc != 0) break;
        end
        In_IFReq = 1'b0; In_MEMControl = 2'b00;
        check("tie_mem_ack_cycle", 32'(mem_cyc), 32'd3);
        check("tie_if_ack_cycle", 32'(if_cyc), 32'd7);
        check("tie_if_data", Out_IFData, 32'h100);
        check("tie_mem_data", Out_MEMData, 32'h40);

        // Both held for four transactions: grants alternate MEM, IF, MEM, IF
        exp_q = {32'd1, 32'd0, 32'd1, 32'd0};
        @(posedge Clk); #1;
        In_IFReq = 1'b1; In_IFAddress = 32'h44;
        In_MEMControl = 2'b10; In_MEMAddress = 32'h14;
        acks = 0;
        for (int n = 1; n <= 60 && acks < 4; n++) begin
            @(posedge Clk); #1;
            if (Out_MEMAck || Out_IFAck) begin
                acks++;
                if (exp_q.size() > 0) check("rr_order", 32'(Out_MEMAck), exp_q.pop_front());
            end
        end
        In_IFReq = 1'b0; In_MEMControl = 2'b00;
        check("rr_ack_count", 32'(acks), 32'd4);

        // Reset during the second access cycle, then the held request completes
        @(posedge Clk); #1;
        In_MEMControl = 2'b10; In_MEMAddress = 32'h20;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("pre_reset_read", 32'(Out_MemRead), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("reset_drops_read", 32'(Out_MemRead), 32'd0);
        check("reset_state", 32'(Out_DbgState), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        ack_cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk); #1;
            if (Out_MEMAck) begin ack_cyc = n; break; end
        end
        In_MEMControl = 2'b00;
        check("post_reset_ack_cycle", 32'(ack_cyc), 32'd3);
        check("post_reset_data", Out_MEMData, 32'h80);

        // Random traffic
        @(posedge Clk); #1;
        rand_en = 1'b1;
        repeat (2500) @(posedge Clk);
        rand_en = 1'b0;
        #1;
        In_IFReq = 1'b0; In_MEMControl = 2'b00;
        repeat (LATENCY + 4) @(posedge Clk);
        #1;
        check("drain_idle", 32'(Out_DbgState), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported data memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access over a fixed multi-cycle memory latency and returns read data plus a one-cycle acknowledge to the winning requester.
- Drives a pipeline stall while any request is outstanding.
- Sits between the IF/MEM pipeline stages and the memory array.

Parameters:
- LATENCY, 2, memory access cycles per transaction (legal 1..15).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- Clk  in  1  single system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- In_IFReq  in  1  fetch request, level; held until Out_IFAck.
- In_IFAddress  in  ADDR_W  fetch address.
- Out_IFData  out  DATA_W  fetched instruction word.
- Out_IFAck  out  1  one-cycle completion pulse for IF.
- In_MEMControl  in  2  [1]=MemRead, [0]=MemWrite; nonzero = MEM request, held until Out_MEMAck.
- In_MEMAddress  in  ADDR_W  load/store address.
- In_MEMData  in  DATA_W  store data.
- Out_MEMData  out  DATA_W  load data.
- Out_MEMAck  out  1  one-cycle completion pulse for MEM.
- Out_Stall  out  1  pipeline stall.
- Out_MemAddr  out  ADDR_W  memory address.
- Out_MemWData  out  DATA_W  memory write data.
- Out_MemRead  out  1  memory read strobe.
- Out_MemWrite  out  1  memory write strobe.
- In_MemRData  in  DATA_W  memory read data; valid in the final access cycle.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-access:
  - State to IDLE; all outputs 0.
  - Access counter cleared.
  - last_grant pointer set to IF.
- State IDLE:
  - Sample both requests at the rising edge.
  - If exactly one is pending, grant it.
  - If both are pending, grant the requester that is not last_grant (round-robin). The first tie after reset therefore goes to MEM.
  - On grant: latch address, write data, op and grantee; load counter = LATENCY-1; update last_grant; go to ACCESS.
  - No request: stay in IDLE.
- State ACCESS:
  - Drive Out_MemAddr from the latched value.
  - Drive Out_MemRead for IF grants and for MEM op 2'b10.
  - Drive Out_MemWrite plus Out_MemWData for MEM op 2'b01 or 2'b11; 2'b11 is treated as a write.
  - Hold the strobes for exactly LATENCY cycles.
  - Decrement the counter each cycle.
  - At the edge where counter==0: capture In_MemRData into the grantee's data register (reads only), drop the strobes, go to RESP.
- State RESP:
  - Assert the grantee's ack for exactly one cycle, then go to IDLE.
- Data registers:
  - Out_IFData and Out_MEMData hold their value until the next read completion for that requester.
  - A write completion leaves Out_MEMData unchanged.
- Latency and throughput:
  - Request sampled at edge E0.
  - Strobes high for cycles E0..E0+LATENCY.
  - Ack high between E0+LATENCY and E0+LATENCY+1.
  - Throughput is one access per LATENCY+2 cycles.
- Out_Stall is combinational: (In_IFReq | |In_MEMControl) & ~(Out_IFAck | Out_MEMAck).
- Input changes during ACCESS are ignored; latched values are used.
- A request withdrawn mid-access: the access still completes and the ack still pulses.
- The requester deasserts its request in the ack cycle. A request still high in IDLE after the ack is treated as a new request.
- Strobes are never both high. No access is ever issued while the state is not ACCESS.

Test Plan (LATENCY=2):
- Reset, no requests -> all outputs 0, Out_Stall=0, state stays IDLE for 10 cycles.
- MEM load: In_MEMControl=2'b10, addr 2; memory returns 32'd8 -> Out_MemRead high for 2 cycles, Out_MEMAck one cycle later, Out_MEMData=8, Out_Stall high until the ack cycle.
- MEM store: In_MEMControl=2'b01, addr 8, data 8 -> Out_MemWrite high 2 cycles with Out_MemAddr=8, Out_MemWData=8; ack pulses; Out_MEMData unchanged.
- Simultaneous IF (addr 0x40) and MEM load (addr 0x10) from reset -> MEM is granted first, IF second. Acks are 4 cycles apart; IF gets the word returned for 0x40.
- Both requests held continuously for 4 transactions -> grants alternate MEM, IF, MEM, IF.
- Rst_n pulled low during the 2nd ACCESS cycle -> strobes drop in the same cycle; no ack is issued; after release, the re-asserted request completes normally.
